mult_sequencer: RTL and testbench
=================================

# mult_sequencer

Iterative shift-and-add multiplier sequencer that executes MULT/MULTU in the R-type path beside the ALU. It holds the HI/LO result registers that MFHI/MFLO read. The sequencer accepts a one-cycle start from decode and runs one partial-product step per clock. While it runs, `busy` is high so the hazard logic can stall the pipeline. A one-cycle `done` marks when HI/LO become valid.

## Interface
- `WIDTH`, default 32: operand width; HI and LO are each `WIDTH` bits.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request, qualified by `ALUFunction`.
- `ALUFunction`  in  6  instruction funct field. 6'b011000 = MULT, 6'b011001 = MULTU; any other value means `start` is ignored.
- `flush`  in  1  synchronous abort of the operation in flight.
- `operand_a`  in  WIDTH  multiplicand (rs); sampled only on an accepted start.
- `operand_b`  in  WIDTH  multiplier (rt); sampled only on an accepted start.
- `busy`  out  1  high in the RUN and DONE states.
- `done`  out  1  one-cycle pulse; HI/LO are valid in that cycle.
- `hi`  out  WIDTH  upper half of the last completed product.
- `lo`  out  WIDTH  lower half of the last completed product.

## Operation
- States and transitions:
  - IDLE → RUN on an accepted start.
  - RUN → DONE after `WIDTH` steps.
  - DONE → IDLE, or DONE → RUN on an accepted start.
- Accepted start means: `start`=1, valid funct, state is IDLE or DONE, and `flush`=0.
- On accept, the block latches:
  - `mcand` = |operand_a| and `mplr` = |operand_b| for a signed op; raw operands otherwise.
  - `neg` = a[W-1] XOR b[W-1] for a signed op; 0 otherwise.
  - `cnt` = 0.
  - `P` = {(WIDTH+1)'b0, mplr}.
- Each RUN cycle:
  - If P[0]=1, add `mcand` to `P[2W:W]`; the sum is WIDTH+1 bits wide, so no carry is lost.
  - Then shift `P` right by 1 and increment `cnt`.
- When `cnt`=WIDTH-1, the same edge moves the state to DONE and writes {hi,lo}:
  - the two's-complement negation of P[2W-1:0] when `neg`=1;
  - P[2W-1:0] otherwise.
- `hi`/`lo` change only on that edge; they hold their value in every other state.
- |x| is taken modulo 2^WIDTH, so 0x80000000 maps to 0x80000000 and is still correct as an unsigned magnitude.
- `flush`=1 in RUN or DONE sends the state to IDLE on the next edge.
  - `hi`/`lo` are not updated and `done` is not asserted.
  - If `flush` arrives on the final RUN edge, the flush wins and HI/LO are not written.
- `start` while in RUN is ignored; no queuing.
- `start` with an invalid funct is ignored in every state.
- Reset values: state IDLE, `cnt` 0, `P` 0, `busy` 0, `done` 0, `hi` 0, `lo` 0.
- Asserting reset mid-operation aborts immediately to those values.

## Timing
- `start` is accepted in cycle 0.
- `busy` is high from cycle 1 through cycle WIDTH+1.
- RUN occupies cycles 1..WIDTH; DONE and `done`=1 are in cycle WIDTH+1. For WIDTH=32, `done` is in cycle 33.
- `done` and `busy` are registered, decoded directly from state; no combinational path from any input.
- Back-to-back operation: a start accepted in the DONE cycle puts RUN in the next cycle. The throughput is one product per WIDTH+1 cycles.
- `hi`/`lo` are stable from cycle WIDTH+1 until the next completing edge.

## Configuration
- `SIGNED_MULT_EN` defined:
  - MULT is handled as signed: magnitude conversion on accept, conditional negation on completion.
  - MULTU is unsigned.
- `SIGNED_MULT_EN` undefined:
  - The abs/negate logic is not built and `neg` is tied to 0.
  - MULT is accepted and executes identically to MULTU.

## Test plan
- MULTU, a=0xFFFFFFFF, b=0xFFFFFFFF → `done` only in cycle 33; hi=0xFFFFFFFE, lo=0x00000001; `busy` high for cycles 1–33.
- MULT, a=0xFFFFFFFD (−3), b=7:
  - with `SIGNED_MULT_EN` → hi=0xFFFFFFFF, lo=0xFFFFFFEB;
  - without it → hi=0x00000006, lo=0xFFFFFFEB.
- MULT, a=0x80000000, b=0x80000000 with `SIGNED_MULT_EN` → hi=0x40000000, lo=0x00000000.
- MULTU 5×6 completes, then MULTU 2×3 is started in cycle 10 and `flush` is asserted in cycle 15:
  - IDLE and `busy`=0 in cycle 16;
  - no `done`;
  - hi/lo stay 0x0/0x1E;
  - a `start` in cycle 20 during the first run is ignored.
- Start asserted in the DONE cycle of a 3×4 product, followed by 0xFFFF×0x10001 → first `done` shows lo=0xC; second `done` arrives 33 cycles later with hi=0x0, lo=0xFFFFFFFF.
- Reset driven low mid-RUN (cycle 12) → `busy`, `done`, `hi`, `lo` are 0 immediately (asynchronous); the next start gives a normal 33-cycle result.

Source files
------------

// File: rtl/mult_sequencer.sv
// Iterative shift-and-add MULT/MULTU sequencer holding the HI/LO result registers.
// Define SIGNED_MULT_EN to build signed MULT (abs on accept, negate on completion).
module mult_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [5:0]       ALUFunction,
    input  logic             flush,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [5:0] FN_MULT  = 6'b011000;
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam int         CNT_W    = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH:0]   prod;
    logic [WIDTH-1:0]   mcand;
    logic               neg;

    logic               valid_fn;
    logic               accept;
    logic               signed_op;
    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH:0]   prod_step;
    logic [2*WIDTH:0]   prod_next;
    logic [2*WIDTH-1:0] result;
    logic               last_step;

    always_comb begin
        valid_fn  = (ALUFunction == FN_MULT) || (ALUFunction == FN_MULTU);
        accept    = start && valid_fn && (state != RUN) && !flush;
        last_step = (cnt == CNT_W'(WIDTH - 1));
    end

`ifdef SIGNED_MULT_EN
    always_comb begin
        signed_op = (ALUFunction == FN_MULT);
        // Magnitude is modulo 2^WIDTH: the most negative value maps to itself.
        abs_a     = (signed_op && operand_a[WIDTH-1]) ? (~operand_a + 1'b1) : operand_a;
        abs_b     = (signed_op && operand_b[WIDTH-1]) ? (~operand_b + 1'b1) : operand_b;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            neg <= 1'b0;
        end else if (accept) begin
            neg <= signed_op && (operand_a[WIDTH-1] ^ operand_b[WIDTH-1]);
        end
    end
`else
    always_comb begin
        signed_op = 1'b0;
        abs_a     = operand_a;
        abs_b     = operand_b;
    end

    assign neg = signed_op;
`endif

    // One partial-product step; the WIDTH+1-bit sum keeps the carry before the shift.
    always_comb begin
        sum       = prod[2*WIDTH:WIDTH] + {1'b0, mcand};
        prod_step = prod[0] ? {sum, prod[WIDTH-1:0]} : prod;
        prod_next = prod_step >> 1;
        result    = neg ? (~prod_next[2*WIDTH-1:0] + 1'b1) : prod_next[2*WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
            prod  <= '0;
            mcand <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (accept) begin
                        state <= RUN;
                        busy  <= 1'b1;
                        mcand <= abs_a;
                        prod  <= {{(WIDTH+1){1'b0}}, abs_b};
                        cnt   <= '0;
                    end else begin
                        busy <= 1'b0;
                    end
                end
                RUN: begin
                    if (flush) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b0;
                    end else begin
                        prod <= prod_next;
                        cnt  <= cnt + 1'b1;
                        if (last_step) begin
                            state    <= DONE;
                            done     <= 1'b1;
                            {hi, lo} <= result;
                        end
                    end
                end
                DONE: begin
                    done <= 1'b0;
                    if (accept) begin
                        state <= RUN;
                        busy  <= 1'b1;
                        mcand <= abs_a;
                        prod  <= {{(WIDTH+1){1'b0}}, abs_b};
                        cnt   <= '0;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_sequencer.sv
// Scoreboard bench for mult_sequencer: stimulus queues expected {hi,lo}, a monitor checks on done.
module tb_mult_sequencer;

    localparam int W = 32;
    localparam logic [5:0] FN_MULT  = 6'b011000;
    localparam logic [5:0] FN_MULTU = 6'b011001;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic [5:0]   fn = 6'd0;
    logic         flush = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int tests = 0;
    int fails = 0;
    logic [2*W-1:0] exp_q[$];
    logic [2*W-1:0] mon_exp;

    mult_sequencer #(.WIDTH(W)) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .ALUFunction(fn),
        .flush(flush),
        .operand_a(a),
        .operand_b(b),
        .busy(busy),
        .done(done),
        .hi(hi),
        .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset && done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 64'd1, 64'd0);
            end else begin
                mon_exp = exp_q.pop_front();
                check("product", {hi, lo}, mon_exp);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents a start for one cycle; returns in cycle 1 of the operation.
    task automatic issue(input logic [5:0] f, input logic [W-1:0] x, input logic [W-1:0] y);
        start = 1'b1;
        fn    = f;
        a     = x;
        b     = y;
        step();
        start = 1'b0;
    endtask

    // Runs from cycle 1 until done (bounded); optionally pokes a start at cycle inj.
    task automatic run(input int inj, output int dcyc, output int bcnt);
        int cyc;
        cyc  = 1;
        dcyc = 0;
        bcnt = 0;
        while (dcyc == 0 && cyc < 100) begin
            if (busy) bcnt++;
            if (done) begin
                dcyc = cyc;
            end else begin
                if (cyc == inj) begin
                    start = 1'b1;
                    fn    = FN_MULTU;
                    a     = 32'd1;
                    b     = 32'd1;
                end else begin
                    start = 1'b0;
                end
                step();
                cyc++;
            end
        end
        start = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int d;
        int bc;

        repeat (3) step();
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_hilo", {hi, lo}, 64'd0);
        reset = 1'b1;
        step();

        issue(6'b100000, 32'd3, 32'd4);
        check("bad_fn_busy", busy, 0);
        step();
        check("bad_fn_busy2", busy, 0);

        // MULTU max x max; a start in cycle 20 must be ignored
        exp_q.push_back(64'hFFFFFFFE_00000001);
        issue(FN_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        run(20, d, bc);
        check("t1_done_cycle", d, 33);
        check("t1_busy_cycles", bc, 33);
        step();
        check("t1_after_busy", {busy, done}, 2'b00);

`ifdef SIGNED_MULT_EN
        exp_q.push_back(64'hFFFFFFFF_FFFFFFEB);
`else
        exp_q.push_back(64'h00000006_FFFFFFEB);
`endif
        issue(FN_MULT, 32'hFFFFFFFD, 32'd7);
        run(0, d, bc);
        check("t2_done_cycle", d, 33);
        step();

        exp_q.push_back(64'h40000000_00000000);
        issue(FN_MULT, 32'h80000000, 32'h80000000);
        run(0, d, bc);
        check("t3_done_cycle", d, 33);
        step();

        // 5x6 completes, then 2x3 is flushed mid-run
        exp_q.push_back(64'd30);
        issue(FN_MULTU, 32'd5, 32'd6);
        run(0, d, bc);
        check("t4_done_cycle", d, 33);
        step();
        issue(FN_MULTU, 32'd2, 32'd3);
        repeat (4) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush_busy", busy, 0);
        check("flush_done", done, 0);
        check("flush_hilo", {hi, lo}, 64'd30);
        repeat (40) step();
        check("flush_idle", busy, 0);

        // flush on the final RUN edge wins over the write
        issue(FN_MULTU, 32'd2, 32'd3);
        repeat (31) step();
        check("late_busy_before", busy, 1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("late_flush_state", {busy, done}, 2'b00);
        check("late_flush_hilo", {hi, lo}, 64'd30);
        repeat (3) step();

        // back-to-back: start in the DONE cycle
        exp_q.push_back(64'd12);
        issue(FN_MULTU, 32'd3, 32'd4);
        run(0, d, bc);
        check("b2b_first_cycle", d, 33);
        exp_q.push_back(64'h00000000_FFFFFFFF);
        issue(FN_MULTU, 32'h0000FFFF, 32'h00010001);
        check("b2b_busy_kept", busy, 1);
        run(0, d, bc);
        check("b2b_second_gap", d, 33);
        step();

        // asynchronous reset mid-run
        issue(FN_MULTU, 32'd7, 32'd9);
        repeat (11) step();
        reset = 1'b0;
        #1;
        check("async_rst_busy", busy, 0);
        check("async_rst_done", done, 0);
        check("async_rst_hilo", {hi, lo}, 64'd0);
        step();
        reset = 1'b1;
        step();
        exp_q.push_back(64'd63);
        issue(FN_MULTU, 32'd7, 32'd9);
        run(0, d, bc);
        check("post_rst_cycle", d, 33);
        step();

        repeat (3) step();
        check("queue_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
